// File: rtl/id_stage.sv
// MIPS decode stage: ALU decode, EX/MEM forwarding, load-use interlock and a registered ID/EX slot.
// Define ID_SHIFT_EN to decode SLL/SRL/SRA; otherwise those funct codes decode as invalid.
module id_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         pc_i,
  input  logic [31:0]         inst_i,
  output logic [REG_AW-1:0]   reg1_addr_o,
  output logic [REG_AW-1:0]   reg2_addr_o,
  output logic                reg1_read_o,
  output logic                reg2_read_o,
  input  logic [DATA_W-1:0]   reg1_data_i,
  input  logic [DATA_W-1:0]   reg2_data_i,
  input  logic                ex_wreg_i,
  input  logic [REG_AW-1:0]   ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_wreg_i,
  input  logic [REG_AW-1:0]   mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         pc_o,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   reg1_o,
  output logic [DATA_W-1:0]   reg2_o,
  output logic [REG_AW-1:0]   wd_o,
  output logic                wreg_o,
  output logic                inst_invalid_o
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [ALUOP_W-1:0] ALUOP_NOP = ALUOP_W'(8'h00);
  localparam logic [ALUOP_W-1:0] ALUOP_AND = ALUOP_W'(8'h24);
  localparam logic [ALUOP_W-1:0] ALUOP_OR  = ALUOP_W'(8'h25);
  localparam logic [ALUOP_W-1:0] ALUOP_XOR = ALUOP_W'(8'h26);
  localparam logic [ALUOP_W-1:0] ALUOP_NOR = ALUOP_W'(8'h27);
  localparam logic [ALUOP_W-1:0] ALUOP_SLL = ALUOP_W'(8'h7C);
  localparam logic [ALUOP_W-1:0] ALUOP_SRL = ALUOP_W'(8'h02);
  localparam logic [ALUOP_W-1:0] ALUOP_SRA = ALUOP_W'(8'h03);

  localparam logic [ALUSEL_W-1:0] SEL_NOP   = ALUSEL_W'(3'b000);
  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'b001);
  localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(3'b010);

  logic [5:0]          op, funct;
  logic [REG_AW-1:0]   rs, rt, rd;
  logic [ALUOP_W-1:0]  dec_aluop;
  logic [ALUSEL_W-1:0] dec_alusel;
  logic                dec_wreg, dec_invalid;
  logic [REG_AW-1:0]   dec_wd;
  logic [DATA_W-1:0]   imm1, imm2;
  logic [DATA_W-1:0]   opnd1, opnd2;
  logic                hazard;

  assign op    = inst_i[31:26];
  assign funct = inst_i[5:0];
  assign rs    = REG_AW'(inst_i[25:21]);
  assign rt    = REG_AW'(inst_i[20:16]);
  assign rd    = REG_AW'(inst_i[15:11]);

  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;

  always_comb begin
    dec_aluop   = ALUOP_NOP;
    dec_alusel  = SEL_NOP;
    dec_wreg    = 1'b0;
    dec_wd      = '0;
    dec_invalid = 1'b1;
    reg1_read_o = 1'b0;
    reg2_read_o = 1'b0;
    imm1        = '0;
    imm2        = '0;
    case (op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        dec_alusel  = SEL_LOGIC;
        dec_aluop   = (op == OP_ORI) ? ALUOP_OR : (op == OP_ANDI) ? ALUOP_AND : ALUOP_XOR;
        reg1_read_o = 1'b1;
        imm2        = DATA_W'(inst_i[15:0]);
        dec_wd      = rt;
        dec_wreg    = 1'b1;
        dec_invalid = 1'b0;
      end
      OP_LUI: begin
        dec_alusel  = SEL_LOGIC;
        dec_aluop   = ALUOP_OR;
        imm2        = DATA_W'({inst_i[15:0], 16'h0000});
        dec_wd      = rt;
        dec_wreg    = 1'b1;
        dec_invalid = 1'b0;
      end
      OP_SPECIAL: begin
        case (funct)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            dec_alusel  = SEL_LOGIC;
            dec_aluop   = (funct == FN_AND) ? ALUOP_AND : (funct == FN_OR) ? ALUOP_OR :
                          (funct == FN_XOR) ? ALUOP_XOR : ALUOP_NOR;
            reg1_read_o = 1'b1;
            reg2_read_o = 1'b1;
            dec_wd      = rd;
            dec_wreg    = 1'b1;
            dec_invalid = 1'b0;
          end
`ifdef ID_SHIFT_EN
          FN_SLL, FN_SRL, FN_SRA: begin
            dec_alusel  = SEL_SHIFT;
            dec_aluop   = (funct == FN_SLL) ? ALUOP_SLL : (funct == FN_SRL) ? ALUOP_SRL : ALUOP_SRA;
            imm1        = DATA_W'(inst_i[10:6]);
            reg2_read_o = 1'b1;
            dec_wd      = rd;
            dec_wreg    = 1'b1;
            dec_invalid = 1'b0;
          end
`else
          // Without shift support only the canonical all-zero NOP is a legal funct-0 word.
          FN_SLL: dec_invalid = (inst_i != '0);
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Priority: immediate when not read, $0 is hard zero, then EX, then MEM, then regfile.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic              rd_en,
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_data,
    input logic [DATA_W-1:0] imm,
    input logic              ex_we,
    input logic [REG_AW-1:0] ex_a,
    input logic [DATA_W-1:0] ex_d,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_a,
    input logic [DATA_W-1:0] mem_d
  );
    if (!rd_en)                      return imm;
    else if (addr == '0)             return '0;
    else if (ex_we && ex_a == addr)  return ex_d;
    else if (mem_we && mem_a == addr) return mem_d;
    else                             return rf_data;
  endfunction

  always_comb begin
    opnd1 = pick_operand(reg1_read_o, rs, reg1_data_i, imm1, ex_wreg_i, ex_wd_i, ex_wdata_i,
                         mem_wreg_i, mem_wd_i, mem_wdata_i);
    opnd2 = pick_operand(reg2_read_o, rt, reg2_data_i, imm2, ex_wreg_i, ex_wd_i, ex_wdata_i,
                         mem_wreg_i, mem_wd_i, mem_wdata_i);
  end

  assign hazard = ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                  ((reg1_read_o && ex_wd_i == rs) || (reg2_read_o && ex_wd_i == rt));

  assign in_ready = flush || (!hazard && (!out_valid || out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      pc_o           <= '0;
      aluop_o        <= '0;
      alusel_o       <= '0;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= '0;
      wreg_o         <= 1'b0;
      inst_invalid_o <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid      <= 1'b1;
      pc_o           <= pc_i;
      aluop_o        <= dec_aluop;
      alusel_o       <= dec_alusel;
      reg1_o         <= opnd1;
      reg2_o         <= opnd2;
      wd_o           <= dec_wd;
      wreg_o         <= dec_wreg;
      inst_invalid_o <= dec_invalid;
    end else if (out_ready) begin
      // Drained with nothing accepted: either a plain transfer or a load-use bubble.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, forwarding, load-use bubble, stall, flush and reset.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [31:0] pc_i, inst_i;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic        reg1_read_o, reg2_read_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        flush, out_valid, out_ready;
  logic [31:0] pc_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o;
  logic [4:0]  wd_o;
  logic        wreg_o, inst_invalid_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_stage #(.DATA_W(32), .REG_AW(5), .ALUOP_W(8), .ALUSEL_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .inst_invalid_o(inst_invalid_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pc_i = '0; inst_i = '0;
    reg1_data_i = '0; reg2_data_i = '0;
    ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
    flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_pc", pc_o, 0);
    check("rst_aluop", aluop_o, 0);
    check("rst_reg2", reg2_o, 0);
    check("rst_wreg", wreg_o, 0);
    rst = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);

    // ori $1,$0,0x1100
    in_valid = 1'b1; pc_i = 32'h100; inst_i = 32'h3401_1100;
    #1;
    check("ori_r1_read", reg1_read_o, 1);
    check("ori_r2_read", reg2_read_o, 0);
    check("ori_r2_addr", reg2_addr_o, 1);
    tick();
    check("ori_valid", out_valid, 1);
    check("ori_aluop", aluop_o, 8'h25);
    check("ori_alusel", alusel_o, 1);
    check("ori_reg1", reg1_o, 0);
    check("ori_reg2", reg2_o, 32'h1100);
    check("ori_wd", wd_o, 1);
    check("ori_wreg", wreg_o, 1);
    check("ori_pc", pc_o, 32'h100);

    // or $3,$1,$2 : EX beats MEM for $1
    pc_i = 32'h104; inst_i = 32'h0022_1825;
    ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hAAAA;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'h5555;
    reg1_data_i = 32'h99; reg2_data_i = 32'd7;
    tick();
    check("or_reg1_ex", reg1_o, 32'hAAAA);
    check("or_reg2_rf", reg2_o, 7);
    check("or_wd", wd_o, 3);
    check("or_pc", pc_o, 32'h104);

    // xor $4,$1,$2 : MEM forward
    ex_wreg_i = 1'b0; inst_i = 32'h0022_2026;
    tick();
    check("xor_reg1_mem", reg1_o, 32'h5555);
    check("xor_aluop", aluop_o, 8'h26);

    // nor $5,$0,$2 : $0 never forwarded
    mem_wd_i = 5'd0; inst_i = 32'h0002_2827;
    tick();
    check("nor_reg1_zero", reg1_o, 0);
    check("nor_aluop", aluop_o, 8'h27);
    check("nor_wd", wd_o, 5);

    // and $4,$2,$5 behind a load to $2
    mem_wreg_i = 1'b0; inst_i = 32'h0045_2024; pc_i = 32'h110;
    ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd2; ex_wdata_i = 32'h1234;
    reg2_data_i = 32'd9;
    #1 check("hazard_in_ready", in_ready, 0);
    tick();
    check("hazard_bubble", out_valid, 0);
    ex_is_load_i = 1'b0;
    #1 check("hazard_clear_ready", in_ready, 1);
    tick();
    check("and_valid", out_valid, 1);
    check("and_reg1_fwd", reg1_o, 32'h1234);
    check("and_reg2", reg2_o, 9);
    check("and_aluop", aluop_o, 8'h24);
    check("and_wd", wd_o, 4);

    // stall 3 cycles, then flush
    out_ready = 1'b0; inst_i = 32'h3407_0077; pc_i = 32'h114;
    #1 check("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_reg1", reg1_o, 32'h1234);
      check("stall_wd", wd_o, 4);
      check("stall_pc", pc_o, 32'h110);
      check("stall_ready", in_ready, 0);
    end
    flush = 1'b1;
    #1 check("flush_in_ready", in_ready, 1);
    tick();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);

    // lui $5,0x1234
    out_ready = 1'b1; ex_wreg_i = 1'b0; inst_i = 32'h3C05_1234;
    #1 check("lui_r1_read", reg1_read_o, 0);
    tick();
    check("lui_reg2", reg2_o, 32'h1234_0000);
    check("lui_reg1", reg1_o, 0);
    check("lui_aluop", aluop_o, 8'h25);
    check("lui_wd", wd_o, 5);

    // andi $8,$3,0xFFFF
    inst_i = 32'h3068_FFFF; reg1_data_i = 32'h55;
    tick();
    check("andi_reg1", reg1_o, 32'h55);
    check("andi_reg2", reg2_o, 32'hFFFF);
    check("andi_aluop", aluop_o, 8'h24);

    // sra $6,$7,4
    inst_i = 32'h0007_3103; reg2_data_i = 32'hF0;
    tick();
`ifdef ID_SHIFT_EN
    check("sra_aluop", aluop_o, 8'h03);
    check("sra_alusel", alusel_o, 2);
    check("sra_reg1", reg1_o, 4);
    check("sra_reg2", reg2_o, 32'hF0);
    check("sra_wd", wd_o, 6);
    check("sra_invalid", inst_invalid_o, 0);
`else
    check("sra_invalid", inst_invalid_o, 1);
    check("sra_wreg", wreg_o, 0);
    check("sra_aluop", aluop_o, 0);

    inst_i = 32'h0000_0000;
    tick();
    check("nop_invalid", inst_invalid_o, 0);
    check("nop_wreg", wreg_o, 0);
`endif

    // reserved opcode
    inst_i = 32'hFC00_0000;
    tick();
    check("rsvd_invalid", inst_invalid_o, 1);
    check("rsvd_wreg", wreg_o, 0);
    check("rsvd_alusel", alusel_o, 0);

    // reset with a valid output and a live hazard
    inst_i = 32'h0045_2024; pc_i = 32'h200;
    ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd2;
    #1 check("pre_rst_hazard", in_ready, 0);
    rst = 1'b1;
    tick();
    check("rst2_valid", out_valid, 0);
    check("rst2_pc", pc_o, 0);
    check("rst2_reg1", reg1_o, 0);
    check("rst2_wd", wd_o, 0);
    check("rst2_invalid", inst_invalid_o, 0);
    rst = 1'b0; ex_is_load_i = 1'b0; ex_wreg_i = 1'b0; in_valid = 1'b0;
    #1 check("rst2_in_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised decode stage for the five-stage MIPS pipeline, sitting between the IF/ID register and the EX stage. It splits an instruction into ALU type, ALU subtype, source operands and destination register. It adds EX/MEM result forwarding, a load-use interlock, and a registered ID/EX output with valid/ready handshake, flush and stall. It supersedes the single-ORI combinational decoder.

## Interface
- `DATA_W`, 32: operand and immediate width. Must be ≥ 32; immediates are extended to `DATA_W`.
- `REG_AW`, 5: register address width.
- `ALUOP_W`, 8: `aluop` width.
- `ALUSEL_W`, 3: `alusel` width.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock; all state updates on rising edge.
- `rst`, in, 1: synchronous reset, active-high (`RstEnable` = 1'b1).
- `in_valid`, in, 1: `pc_i`/`inst_i` valid.
- `in_ready`, out, 1: stage accepts an instruction this cycle.
- `pc_i`, in, 32: instruction address.
- `inst_i`, in, 32: instruction word.
- `reg1_addr_o` / `reg2_addr_o`, out, REG_AW: regfile read addresses (rs, rt), combinational.
- `reg1_read_o` / `reg2_read_o`, out, 1: regfile read enables, combinational.
- `reg1_data_i` / `reg2_data_i`, in, DATA_W: regfile read data, same cycle.
- `ex_wreg_i`, `ex_wd_i`, `ex_wdata_i`, `ex_is_load_i`, in, 1/REG_AW/DATA_W/1: EX-stage write-back info.
- `mem_wreg_i`, `mem_wd_i`, `mem_wdata_i`, in, 1/REG_AW/DATA_W: MEM-stage write-back info.
- `flush`, in, 1: kill the held and incoming instruction.
- `out_valid`, out, 1: ID/EX register holds an instruction.
- `out_ready`, in, 1: EX consumes the instruction.
- `pc_o`, out, 32: registered PC.
- `aluop_o`, out, ALUOP_W: registered ALU subtype.
- `alusel_o`, out, ALUSEL_W: registered ALU type.
- `reg1_o` / `reg2_o`, out, DATA_W: registered source operands.
- `wd_o`, out, REG_AW: registered destination register.
- `wreg_o`, out, 1: registered write-enable.
- `inst_invalid_o`, out, 1: registered reserved-instruction flag.

## Operation
Decode (op = inst[31:26], funct = inst[5:0]):
- ORI 001101 / ANDI 001100 / XORI 001110: alusel LOGIC 3'b001, aluop OR 8'h25 / AND 8'h24 / XOR 8'h26. Reads rs only; imm = zero-extended inst[15:0]; wd = rt.
- LUI 001111: aluop OR, reg1 = 0, reg2 = {inst[15:0], 16'h0} zero-extended; wd = rt; no reads.
- SPECIAL 000000, funct AND 100100 / OR 100101 / XOR 100110 / NOR 100111 (aluop 8'h27): reads rs and rt; wd = rd.
- SLL 000000 / SRL 000010 / SRA 000011 (macro-gated): alusel SHIFT 3'b010, aluop 8'h7C / 8'h02 / 8'h03. reg1 = zero-extended sa (inst[10:6]), reg2 = rt data; wd = rd.
- All other encodings: aluop NOP 8'h00, alusel NOP 3'b000, wreg 0, no reads, `inst_invalid` = 1.

Operand selection:
- If read enabled: EX forward when `ex_wreg_i` and `ex_wd_i` == addr. Otherwise MEM forward on the same condition. Otherwise regfile data.
- If read not enabled: the immediate.
- Address 0 is never forwarded and always yields 0.

Load-use stall:
- `hazard` = `ex_is_load_i` & `ex_wreg_i` & `ex_wd_i` ≠ 0 & matches an enabled read address.
- `in_ready` = !`hazard` & (!`out_valid` | `out_ready`).
- `in_ready` is forced to 1 during `flush`; the incoming instruction is discarded, not captured.

## Timing
- Reset: `out_valid` = 0, `pc_o` = 0, `aluop_o` = 0, `alusel_o` = 0, `reg1_o` = 0, `reg2_o` = 0, `wd_o` = 0, `wreg_o` = 0, `inst_invalid_o` = 0. `in_ready` = 1 in the cycle after reset. Reset mid-transfer discards everything.
- Latency: 1 cycle from the accept edge (`in_valid` & `in_ready`) to `out_valid`.
- Transfer on `out_valid` & `out_ready`. A new accept in the same cycle refills the register back-to-back.
- `out_valid` & !`out_ready`: all registered outputs are held stable, `in_ready` = 0.
- Hazard cycle with `out_ready` = 1: `out_valid` drops to 0 (a bubble is inserted). The instruction is re-decoded next cycle with forwarded EX→MEM data.
- `flush` has priority over accept and hold: `out_valid` ← 0 on the next edge.
- Register-read outputs are combinational from `inst_i`, not registered.

## Configuration
- `ID_SHIFT_EN` defined: SLL/SRL/SRA decode as specified.
- Not defined: those funct codes decode as invalid (NOP, `wreg` 0, `inst_invalid` 1). The all-zero word still yields NOP with `wreg` 0 and `inst_invalid` 0.

## Test plan
- Reset, then `ori $1,$0,0x1100` with `out_ready` = 1 → next cycle `out_valid` = 1, aluop 8'h25, alusel 1, `reg1_o` = 0, `reg2_o` = 0x1100, `wd_o` = 1, `wreg_o` = 1.
- `or $3,$1,$2` with `ex_wd_i` = 1 / `ex_wdata_i` = 0xAAAA and `mem_wd_i` = 1 / `mem_wdata_i` = 0x5555, `reg2_data_i` = 7 → `reg1_o` = 0xAAAA (EX priority), `reg2_o` = 7.
- `ex_is_load_i` = 1, `ex_wd_i` = 2, inst `and $4,$2,$5` → `in_ready` = 0 and one bubble (`out_valid` = 0). Next cycle with the load cleared → accepted, `out_valid` = 1.
- `out_ready` = 0 for 3 cycles with `out_valid` = 1 → outputs unchanged, `in_ready` = 0. `flush` pulse → `out_valid` = 0 next cycle.
- `lui $5,0x1234` → `reg2_o` = 0x12340000, `reg1_o` = 0. `sra $6,$7,4` → aluop 8'h03, `reg1_o` = 4 with `ID_SHIFT_EN`; with it undefined → `inst_invalid_o` = 1, `wreg_o` = 0.
- `rst` asserted while `out_valid` = 1 and a hazard is present → next cycle all outputs 0, `in_ready` = 1.
